// File: rtl/fp_div_sequencer.sv
// Newton-Raphson FP32 divider sequencer. Computes a/b by time-sharing one
// external multiplier and one external combinational adder under a valid/ready FSM.
module fp_div_sequencer #(
  parameter int XLEN    = 32,
  parameter int ITER    = 3,
  parameter int MUL_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] mul_result,
  input  logic            mul_ovf,
  input  logic            mul_unf,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_result
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_SEED_MUL = 4'd1;
  localparam logic [3:0] S_SEED_ADD = 4'd2;
  localparam logic [3:0] S_IT_MUL1  = 4'd3;
  localparam logic [3:0] S_IT_ADD   = 4'd4;
  localparam logic [3:0] S_IT_MUL2  = 4'd5;
  localparam logic [3:0] S_RECIP    = 4'd6;
  localparam logic [3:0] S_FINAL    = 4'd7;
  localparam logic [3:0] S_SPECIAL  = 4'd8;
  localparam logic [3:0] S_DONE     = 4'd9;

  localparam int             LW        = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [LW-1:0]  LAT_LAST  = LW'(MUL_LAT - 1);
  localparam logic [2:0]     ITER_LAST = 3'(ITER - 1);

  // Linear seed x0 = 48/17 - 32/17*bn for bn in [0.5, 1)
  localparam logic [31:0] SEED_K = 32'h3FF0F0F1;
  localparam logic [31:0] SEED_C = 32'h4034B4B5;
  localparam logic [31:0] TWO    = 32'h40000000;

  logic [3:0]      state_q, state_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] x_q, x_d, t_q, t_d;
  logic [XLEN-1:0] recip_q, recip_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [9:0]      e_q, e_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [2:0]      iter_q, iter_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, exc_q, exc_d;

  logic [XLEN-1:0] bn;
  logic [9:0]      e_calc;
  logic            mul_state, mul_last, special_in;

  assign bn         = {1'b0, 8'd126, b_q[22:0]};
  assign e_calc     = {2'b00, x_q[30:23]} + 10'd126 - {2'b00, b_q[30:23]};
  assign mul_state  = (state_q == S_SEED_MUL) || (state_q == S_IT_MUL1) ||
                      (state_q == S_IT_MUL2)  || (state_q == S_FINAL);
  assign mul_last   = (lat_q == LAT_LAST);
  assign special_in = (b[30:0] == 31'd0) || (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    x_d      = x_q;
    t_d      = t_q;
    recip_d  = recip_q;
    result_d = result_q;
    e_d      = e_q;
    lat_d    = lat_q;
    iter_d   = iter_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    exc_d    = exc_q;
    mul_a    = '0;
    mul_b    = '0;
    add_a    = '0;
    add_b    = '0;

    if (mul_state)
      lat_d = mul_last ? '0 : lat_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          lat_d   = '0;
          iter_d  = '0;
          state_d = special_in ? S_SPECIAL : S_SEED_MUL;
        end
      end
      S_SEED_MUL: begin
        mul_a = bn;
        mul_b = SEED_K;
        if (mul_last) begin
          t_d     = mul_result;
          state_d = S_SEED_ADD;
        end
      end
      S_SEED_ADD: begin
        add_a   = SEED_C;
        add_b   = {1'b1, t_q[30:0]};
        x_d     = add_result;
        state_d = S_IT_MUL1;
      end
      S_IT_MUL1: begin
        mul_a = bn;
        mul_b = x_q;
        if (mul_last) begin
          t_d     = mul_result;
          state_d = S_IT_ADD;
        end
      end
      S_IT_ADD: begin
        add_a   = TWO;
        add_b   = {~t_q[31], t_q[30:0]};
        t_d     = add_result;
        state_d = S_IT_MUL2;
      end
      S_IT_MUL2: begin
        mul_a = x_q;
        mul_b = t_q;
        if (mul_last) begin
          x_d = mul_result;
          if (iter_q == ITER_LAST) begin
            state_d = S_RECIP;
          end else begin
            iter_d  = iter_q + 3'd1;
            state_d = S_IT_MUL1;
          end
        end
      end
      S_RECIP: begin
        // Re-apply the divisor exponent that was stripped when normalising to bn
        e_d     = e_calc;
        recip_d = {b_q[31], e_calc[7:0], x_q[22:0]};
        state_d = S_FINAL;
      end
      S_FINAL: begin
        mul_a = a_q;
        mul_b = recip_q;
        if (mul_last) begin
          result_d = mul_result;
          ovf_d    = mul_ovf || ($signed(e_q) > 10'sd254);
          unf_d    = mul_unf || ($signed(e_q) < 10'sd1);
          exc_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_SPECIAL: begin
        // Held two cycles so special operands have a fixed latency of 2
        if (!lat_q[0]) begin
          lat_d = LW'(1);
        end else begin
          lat_d    = '0;
          result_d = (b_q[30:0] == 31'd0) ? {a_q[31] ^ b_q[31], 8'hFF, 23'h0}
                                          : 32'h7FC00000;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          exc_d    = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          result_d = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          exc_d    = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      t_q      <= '0;
      recip_q  <= '0;
      result_q <= '0;
      e_q      <= '0;
      lat_q    <= '0;
      iter_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      x_q      <= x_d;
      t_q      <= t_d;
      recip_q  <= recip_d;
      result_q <= result_d;
      e_q      <= e_d;
      lat_q    <= lat_d;
      iter_q   <= iter_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      exc_q    <= exc_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign exception = exc_q;

endmodule

// File: tb/tb_fp_div_sequencer.sv
// Directed bench for fp_div_sequencer with behavioural FP32 multiplier/adder models;
// a second instance runs with a two-cycle multiplier.
module tb_fp_div_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // FP32 <-> real helpers, denormals flushed, round half-up on conversion back
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [33:0] r2f(input real r);
    logic [63:0] d;
    logic [24:0] m;
    int          e;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {2'b00, d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    m = {2'b01, d[51:29]} + {24'd0, d[28]};
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, d[63], 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, d[63], 31'd0};
    return {2'b00, d[63], 8'(e), m[22:0]};
  endfunction

  function automatic int ulp_diff(input logic [31:0] x, input logic [31:0] y);
    int d;
    d = int'(x) - int'(y);
    return (d < 0) ? -d : d;
  endfunction

  // Instance 1: MUL_LAT = 1
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0, result;
  logic        overflow, underflow, exception;
  logic [31:0] mul_a, mul_b, mul_result, add_a, add_b, add_result;
  logic        mul_ovf, mul_unf;
  logic [33:0] mr1, ar1;

  always_comb mr1 = r2f(f2r(mul_a) * f2r(mul_b));
  always_comb ar1 = r2f(f2r(add_a) + f2r(add_b));
  assign mul_result = mr1[31:0];
  assign mul_ovf    = mr1[33];
  assign mul_unf    = mr1[32];
  assign add_result = ar1[31:0];

  fp_div_sequencer #(.XLEN(32), .ITER(3), .MUL_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .exception(exception),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .mul_ovf(mul_ovf), .mul_unf(mul_unf),
    .add_a(add_a), .add_b(add_b), .add_result(add_result)
  );

  // Instance 2: MUL_LAT = 2, multiplier product registered once
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b1;
  logic [31:0] a2 = '0, b2 = '0, result2;
  logic        overflow2, underflow2, exception2;
  logic [31:0] mul_a2, mul_b2, add_a2, add_b2, add_result2;
  logic [33:0] mr2_q = '0, ar2;

  always @(posedge clk) mr2_q <= r2f(f2r(mul_a2) * f2r(mul_b2));
  always_comb ar2 = r2f(f2r(add_a2) + f2r(add_b2));
  assign add_result2 = ar2[31:0];

  fp_div_sequencer #(.XLEN(32), .ITER(3), .MUL_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
    .overflow(overflow2), .underflow(underflow2), .exception(exception2),
    .mul_a(mul_a2), .mul_b(mul_b2), .mul_result(mr2_q[31:0]),
    .mul_ovf(mr2_q[33]), .mul_unf(mr2_q[32]),
    .add_a(add_a2), .add_b(add_b2), .add_result(add_result2)
  );

  // Issue one request on instance 1 and wait (bounded) for out_valid
  task automatic do_div(input logic [31:0] aa, input logic [31:0] bb, output int lat);
    a = aa;
    b = bb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 00000000", result); end
    n_tests++; if ({mul_a, mul_b, add_a, add_b} !== 128'h0) begin n_fail++; $display("FAIL reset_operands: got %h %h %h %h want 0", mul_a, mul_b, add_a, add_b); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_during_rst: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic;
    int lat;
    do_div(32'h40C00000, 32'h40400000, lat);
    n_tests++; if (lat != 13) begin n_fail++; $display("FAIL basic_latency: got %0d want 13", lat); end
    n_tests++; if (ulp_diff(result, 32'h40000000) > 2) begin n_fail++; $display("FAIL basic_result: got %h want 40000000 +-2ulp", result); end
    n_tests++; if ({overflow, underflow, exception} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: got %b want 000", {overflow, underflow, exception}); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_release: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_negative;
    int lat;
    do_div(32'hBF800000, 32'h40800000, lat);
    n_tests++; if (lat != 13) begin n_fail++; $display("FAIL neg_latency: got %0d want 13", lat); end
    n_tests++; if (ulp_diff(result, 32'hBE800000) > 2) begin n_fail++; $display("FAIL neg_result: got %h want BE800000 +-2ulp", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul_lat2;
    int lat;
    a2 = 32'hBF800000;
    b2 = 32'h40800000;
    in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++; if (lat != 21) begin n_fail++; $display("FAIL lat2_latency: got %0d want 21", lat); end
    n_tests++; if (ulp_diff(result2, 32'hBE800000) > 2) begin n_fail++; $display("FAIL lat2_result: got %h want BE800000 +-2ulp", result2); end
    n_tests++; if ({overflow2, underflow2, exception2} !== 3'b000) begin n_fail++; $display("FAIL lat2_flags: got %b want 000", {overflow2, underflow2, exception2}); end
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero;
    int lat;
    logic mul_busy;
    a = 32'h3F800000;
    b = 32'h00000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    mul_busy = (mul_a != 0) || (mul_b != 0);
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (mul_a != 0 || mul_b != 0) mul_busy = 1'b1;
    end
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL zero_latency: got %0d want 2", lat); end
    n_tests++; if (result !== 32'h7F800000) begin n_fail++; $display("FAIL zero_result: got %h want 7F800000", result); end
    n_tests++; if ({overflow, underflow, exception} !== 3'b001) begin n_fail++; $display("FAIL zero_flags: got %b want 001", {overflow, underflow, exception}); end
    n_tests++; if (mul_busy !== 1'b0) begin n_fail++; $display("FAIL zero_mul_idle: got busy=%b want 0", mul_busy); end
    @(posedge clk); #1;
    // Negative zero divisor flips the sign of the infinity
    do_div(32'h3F800000, 32'h80000000, lat);
    n_tests++; if (result !== 32'hFF800000) begin n_fail++; $display("FAIL negzero_result: got %h want FF800000", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_nan;
    int lat;
    do_div(32'h7F800000, 32'h3F800000, lat);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL nan_latency: got %0d want 2", lat); end
    n_tests++; if (result !== 32'h7FC00000 || exception !== 1'b1) begin n_fail++; $display("FAIL nan_result: got %h exc=%b want 7FC00000 exc=1", result, exception); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] held;
    logic [2:0]  held_flags;
    logic        stable;
    out_ready = 1'b0;
    do_div(32'h3F800000, 32'h40000000, lat);
    n_tests++; if (ulp_diff(result, 32'h3F000000) > 2) begin n_fail++; $display("FAIL bp_result: got %h want 3F000000 +-2ulp", result); end
    held = result;
    held_flags = {overflow, underflow, exception};
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== held || {overflow, underflow, exception} !== held_flags || in_ready !== 1'b0)
        stable = 1'b0;
    end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got stable=%b want 1 (valid=%b ready=%b res=%h)", stable, out_valid, in_ready, result); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h0) begin n_fail++; $display("FAIL bp_release: got valid=%b ready=%b res=%h want 0 1 00000000", out_valid, in_ready, result); end
    do_div(32'h41200000, 32'h40A00000, lat);
    n_tests++; if (lat != 13) begin n_fail++; $display("FAIL b2b_latency: got %0d want 13", lat); end
    n_tests++; if (ulp_diff(result, 32'h40000000) > 2) begin n_fail++; $display("FAIL b2b_result: got %h want 40000000 +-2ulp", result); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic stray;
    a = 32'h40C00000;
    b = 32'h40400000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0 || {mul_a, mul_b, add_a, add_b} !== 128'h0) begin n_fail++; $display("FAIL rmid_state: got valid=%b mul_a=%h add_a=%h want 0", out_valid, mul_a, add_a); end
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    n_tests++; if (stray !== 1'b0) begin n_fail++; $display("FAIL rmid_stray_valid: got %b want 0", stray); end
  endtask

  task automatic test_overflow;
    int lat;
    do_div(32'h7F000000, 32'h00800000, lat);
    n_tests++; if (lat != 13) begin n_fail++; $display("FAIL ovf_latency: got %0d want 13", lat); end
    n_tests++; if (overflow !== 1'b1 || exception !== 1'b0) begin n_fail++; $display("FAIL ovf_flags: got ovf=%b exc=%b want 1 0", overflow, exception); end
    @(posedge clk); #1;
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b want 0", overflow); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_mul_lat2;
    test_div_zero;
    test_nan;
    test_back_to_back;
    test_reset_mid;
    test_overflow;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_div_sequencer.md
Name: fp_div_sequencer

Overview:
Multi-cycle Newton-Raphson FP32 divider controller. It computes result = A/B by time-sharing one external FloatingMultiplication instance and one external FloatingAddition instance. A fully unrolled divider uses 8 multipliers and 4 adders; this block replaces that with a valid/ready FSM.

Parameters:
XLEN, 32, operand width (IEEE-754 single only)
ITER, 3, Newton-Raphson iterations (1..4)
MUL_LAT, 1, cycles the shared multiplier needs before mul_result is valid (1 = combinational)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand request
in_ready  out  1  block can accept operands
a  in  XLEN  dividend
b  in  XLEN  divisor
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  XLEN  quotient
overflow  out  1  final multiply overflowed
underflow  out  1  final multiply underflowed
exception  out  1  special operand (B zero, A or B exponent 255)
mul_a, mul_b  out  XLEN  shared multiplier operands
mul_result  in  XLEN  shared multiplier product
mul_ovf, mul_unf  in  1  shared multiplier flags
add_a, add_b  out  XLEN  shared adder operands (combinational adder)
add_result  in  XLEN  shared adder sum

Behaviour:
- Handshake:
  - Accept when in_valid && in_ready; a and b are latched.
  - in_ready = (state==IDLE) && !rst.
  - Result is held stable in DONE until out_valid && out_ready, then FSM returns to IDLE.
  - No new accept is possible in the DONE→IDLE transition cycle.
- Normalised divisor: bn = {1'b0, 8'd126, b[22:0]}, in [0.5, 1).
- States and transitions:
  - IDLE
  - SEED_MUL: mul = bn × 0x3FF0F0F1; t = product.
  - SEED_ADD: add = 0x4034B4B5 + {1, t[30:0]}; x = sum.
  - For k = 1..ITER:
    - IT_MUL1: mul = bn × x; t = product.
    - IT_ADD: add = 0x40000000 + {~t[31], t[30:0]}; t = sum.
    - IT_MUL2: mul = x × t; x = product.
  - RECIP: e = x[30:23] + 126 − b[30:23], computed in 10-bit signed. recip = {b[31], e[7:0], x[22:0]}.
  - FINAL: mul = a × recip. Capture result, ovf, unf. Overflow is also set if e > 254; underflow is also set if e < 1.
  - DONE: out_valid = 1.
- Multiplier timing:
  - Each MUL state holds mul_a/mul_b stable for exactly MUL_LAT cycles.
  - mul_result is registered on the last of those cycles.
- Adder timing: each ADD state lasts 1 cycle, with add_result registered the same cycle.
- Idle outputs: when the unit is not in use, mul_*/add_* drive 0.
- Latency, from the accepting edge to the first cycle with out_valid = 1: MUL_LAT·(2·ITER+2) + ITER + 2. With defaults this is 13 cycles.
- Special operands (checked at accept; go IDLE→SPECIAL→DONE, latency 2, datapath untouched, exception = 1):
  - B = ±0 → result = {a[31]^b[31], 8'hFF, 23'h0}.
  - a[30:23] == 255 or b[30:23] == 255 → result = 32'h7FC00000.
  - In the ±0 case, exception = 1 and overflow = underflow = 0.
- Reset:
  - rst = 1 at any state, including mid-iteration, returns the FSM to IDLE on that edge.
  - out_valid, result, overflow, underflow, exception and all datapath operand outputs reset to 0.
  - Internal x and t reset to 0.
  - The in-flight operation is discarded; no out_valid follows.
- Back-pressure: out_ready = 0 holds DONE and all outputs indefinitely. in_ready stays 0 meanwhile.
- Flags are valid only while out_valid = 1 and are cleared on return to IDLE.

Test Plan:
- Basic divide: a=0x40C00000 (6.0), b=0x40400000 (3.0), out_ready=1.
  → out_valid exactly 13 cycles after accept; result within ±2 ulp of 0x40000000; flags 0.
- Negative operands: a=0xBF800000 (−1.0), b=0x40800000 (4.0).
  → result ≈ 0xBE800000 (±2 ulp).
  - Repeat with MUL_LAT=2 → latency 21 cycles.
- Divide by zero: b=0x00000000, a=0x3F800000.
  → exception=1, result=0x7F800000, out_valid 2 cycles after accept; mul_a/mul_b remain 0 throughout.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid.
  → result and flags stable, in_ready=0.
  - Raise out_ready → IDLE next cycle; a second request is accepted on the following edge.
- Reset mid-operation: assert rst in cycle 6 of a divide.
  → next cycle state IDLE, out_valid=0, in_ready=1 after rst drops; no stray out_valid.
- Exponent overflow: a=0x7F000000, b=0x00800000.
  → overflow=1, exception=0.
